// File: rtl/conv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : conv_mem_pkg
// Description : Shared widths, bank selects, FSM encoding and error-bit
//               indices for the convolution layer memory.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_mem_pkg;

    localparam int DW       = 20;
    localparam int L0_AW    = 12;
    localparam int L1_AW    = 10;
    localparam int L0_DEPTH = 1 << L0_AW;
    localparam int L1_DEPTH = 1 << L1_AW;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CLEAR = 2'd1;
    localparam state_t ST_DUMP  = 2'd2;

    localparam int ERR_CSEL = 0;
    localparam int ERR_ADDR = 1;
    localparam int ERR_BUSY = 2;

endpackage
`default_nettype wire

// File: rtl/conv_layer_mem_if.sv
`default_nettype none
// ============================================================================
// Interface   : conv_layer_mem_if
// Description : Engine csel/cwr/crd bus plus host clear/dump/error signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_layer_mem_if;
    import conv_mem_pkg::*;

    logic [2:0]       csel;
    logic             cwr;
    logic [L0_AW-1:0] caddr_wr;
    logic [DW-1:0]    cdata_wr;
    logic             crd;
    logic [L0_AW-1:0] caddr_rd;
    logic [DW-1:0]    cdata_rd;
    logic             clr_req;
    logic             dump_req;
    logic [2:0]       dump_sel;
    logic             dump_valid;
    logic             dump_ready;
    logic [L0_AW-1:0] dump_addr;
    logic [DW-1:0]    dump_data;
    logic             dump_done;
    logic             mem_busy;
    logic [2:0]       err;
    logic             err_clr;

    modport slave (
        input  csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd,
        input  clr_req, dump_req, dump_sel, dump_ready, err_clr,
        output cdata_rd, dump_valid, dump_addr, dump_data, dump_done,
        output mem_busy, err
    );

    modport master (
        output csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd,
        output clr_req, dump_req, dump_sel, dump_ready, err_clr,
        input  cdata_rd, dump_valid, dump_addr, dump_data, dump_done,
        input  mem_busy, err
    );

endinterface
`default_nettype wire

// File: rtl/conv_mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : conv_mem_bank
// Description : Single-write, dual asynchronous-read memory bank.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mem_bank #(
    parameter int AW = 10,
    parameter int DW = 20
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [AW-1:0] raddr_a,
    output logic      [DW-1:0] rdata_a,
    input  wire logic [AW-1:0] raddr_b,
    output logic      [DW-1:0] rdata_b
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/conv_layer_mem.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_mem
// Description : Layer-memory responder (L0 4096x20, L1 1024x20) with bank
//               clear and valid/ready dump. Optional macro RD_FWD_EN enables
//               write-to-read forwarding on same-address collisions.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_mem
    import conv_mem_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    conv_layer_mem_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic [L0_AW-1:0] r_cnt;
    logic [L0_AW-1:0] r_dump_addr;
    logic             r_dump_l1;
    logic             r_dump_valid;
    logic [DW-1:0]    r_dump_data;
    logic             r_dump_done;
    logic [2:0]       r_err;

    logic             w_sel_l0, w_sel_l1;
    logic             w_wr_inrange, w_rd_inrange;
    logic             w_eng_we;
    logic             w_dump_sel_ok, w_start_clr, w_start_dump;
    logic             w_dump_hs, w_last_dump;
    logic             w_clearing, w_busy;
    logic [2:0]       w_err_set;

    logic             w_l0_we, w_l1_we;
    logic [L0_AW-1:0] w_l0_waddr;
    logic [L1_AW-1:0] w_l1_waddr;
    logic [DW-1:0]    w_wdata;
    logic [DW-1:0]    w_l0_rd, w_l1_rd, w_l0_dump, w_l1_dump;
    logic [DW-1:0]    w_cdata_rd;

    // ---------------- decode ----------------
    assign w_sel_l0     = (bus.csel == CSEL_L0);
    assign w_sel_l1     = (bus.csel == CSEL_L1);
    assign w_wr_inrange = w_sel_l0 | (w_sel_l1 & (bus.caddr_wr[L0_AW-1:L1_AW] == '0));
    assign w_rd_inrange = w_sel_l0 | (w_sel_l1 & (bus.caddr_rd[L0_AW-1:L1_AW] == '0));
    assign w_eng_we     = bus.cwr & w_wr_inrange & (r_state != ST_CLEAR);

    assign w_dump_sel_ok = (bus.dump_sel == CSEL_L0) | (bus.dump_sel == CSEL_L1);
    assign w_start_clr   = (r_state == ST_IDLE) & bus.clr_req;
    assign w_start_dump  = (r_state == ST_IDLE) & bus.dump_req & ~bus.clr_req & w_dump_sel_ok;
    assign w_dump_hs     = r_dump_valid & bus.dump_ready;
    assign w_last_dump   = (r_dump_addr == (r_dump_l1 ? L0_AW'(L1_DEPTH - 1)
                                                      : L0_AW'(L0_DEPTH - 1)));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_clr) begin
                    w_next = ST_CLEAR;
                end else if (w_start_dump) begin
                    w_next = ST_DUMP;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == '1) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DUMP: begin
                if (w_dump_hs & w_last_dump) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_clearing = (r_state == ST_CLEAR);
        w_busy     = (r_state != ST_IDLE);
    end

    // Clear sweeps L0 fully and L1 only over its first 1024 counter values.
    assign w_l0_we    = w_clearing | (w_eng_we & w_sel_l0);
    assign w_l1_we    = w_clearing ? (r_cnt[L0_AW-1:L1_AW] == '0) : (w_eng_we & w_sel_l1);
    assign w_l0_waddr = w_clearing ? r_cnt : bus.caddr_wr;
    assign w_l1_waddr = w_clearing ? r_cnt[L1_AW-1:0] : bus.caddr_wr[L1_AW-1:0];
    assign w_wdata    = w_clearing ? '0 : bus.cdata_wr;

    conv_mem_bank #(.AW(L0_AW), .DW(DW)) u_bank_l0 (
        .clk     (clk),
        .we      (w_l0_we),
        .waddr   (w_l0_waddr),
        .wdata   (w_wdata),
        .raddr_a (bus.caddr_rd),
        .rdata_a (w_l0_rd),
        .raddr_b (r_dump_addr),
        .rdata_b (w_l0_dump)
    );

    conv_mem_bank #(.AW(L1_AW), .DW(DW)) u_bank_l1 (
        .clk     (clk),
        .we      (w_l1_we),
        .waddr   (w_l1_waddr),
        .wdata   (w_wdata),
        .raddr_a (bus.caddr_rd[L1_AW-1:0]),
        .rdata_a (w_l1_rd),
        .raddr_b (r_dump_addr[L1_AW-1:0]),
        .rdata_b (w_l1_dump)
    );

    // ---------------- engine read path ----------------
    always_comb begin
        w_cdata_rd = '0;
        if (bus.crd & w_rd_inrange) begin
            w_cdata_rd = w_sel_l0 ? w_l0_rd : w_l1_rd;
        end
`ifdef RD_FWD_EN
        if (bus.crd & w_rd_inrange & w_eng_we & (bus.caddr_wr == bus.caddr_rd)) begin
            w_cdata_rd = bus.cdata_wr;
        end
`endif
    end

    // ---------------- error detection ----------------
    always_comb begin
        w_err_set           = '0;
        w_err_set[ERR_CSEL] = ((bus.cwr | bus.crd) & ~(w_sel_l0 | w_sel_l1)) |
                              ((r_state == ST_IDLE) & bus.dump_req & ~bus.clr_req & ~w_dump_sel_ok);
        w_err_set[ERR_ADDR] = w_sel_l1 &
                              ((bus.cwr & (bus.caddr_wr[L0_AW-1:L1_AW] != '0)) |
                               (bus.crd & (bus.caddr_rd[L0_AW-1:L1_AW] != '0)));
        w_err_set[ERR_BUSY] = bus.cwr & w_clearing;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_dump_addr  <= '0;
            r_dump_l1    <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_data  <= '0;
            r_dump_done  <= 1'b0;
            r_err        <= '0;
        end else begin
            // A fresh error wins over a same-cycle clear.
            r_err       <= (bus.err_clr ? 3'b000 : r_err) | w_err_set;
            r_cnt       <= w_clearing ? r_cnt + L0_AW'(1) : '0;
            r_dump_done <= (r_state == ST_DUMP) & w_dump_hs & w_last_dump;
            if (w_start_dump) begin
                r_dump_addr  <= '0;
                r_dump_l1    <= (bus.dump_sel == CSEL_L1);
                r_dump_valid <= 1'b0;
            end else if (r_state == ST_DUMP) begin
                if (!r_dump_valid) begin
                    r_dump_data  <= r_dump_l1 ? w_l1_dump : w_l0_dump;
                    r_dump_valid <= 1'b1;
                end else if (w_dump_hs) begin
                    r_dump_valid <= 1'b0;
                    if (!w_last_dump) begin
                        r_dump_addr <= r_dump_addr + L0_AW'(1);
                    end
                end
            end
        end
    end

    assign bus.cdata_rd   = w_cdata_rd;
    assign bus.dump_valid = r_dump_valid;
    assign bus.dump_addr  = r_dump_addr;
    assign bus.dump_data  = r_dump_data;
    assign bus.dump_done  = r_dump_done;
    assign bus.mem_busy   = w_busy;
    assign bus.err        = r_err;

endmodule
`default_nettype wire
